ctrl_seq: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle controller in the javk-cpu core.
- Accepts one instruction at a time from the fetch stage over a valid/ready handshake and latches it.
- Decodes the latched instruction, then sequences memory, ALU and nibble-register operations with explicit handshakes and one-cycle retire/error pulses.
- Replaces the dual-edge ALU clock with a synchronous start/done handshake and adds a memory-access timeout.

---
 rtl/ctrl_seq_pkg.sv | 21 ++
 rtl/ctrl_timeout.sv | 31 +++
 rtl/ctrl_seq.sv | 171 +++++++++++++++++
 tb/tb_ctrl_seq.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_seq_pkg.sv
// Shared opcode map and FSM state encoding for the multi-cycle sequencer.
package ctrl_seq_pkg;

  // Opcodes with bit 3 clear are ALU operations; their low bits select the ALU op.
  localparam int OPCODE_LDB = 8;
  localparam int OPCODE_STB = 9;
  localparam int OPCODE_LNL = 10;
  localparam int OPCODE_LNH = 11;

  // Opcode bit that separates ALU operations (0) from everything else (1).
  localparam int OPCODE_ARITHMETIC_BIT = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM    = 3'd2,
    ST_ALU    = 3'd3,
    ST_EXEC   = 3'd4
  } state_e;

endpackage

// File: rtl/ctrl_timeout.sv
// Loadable down-counter with zero and about-to-expire flags; saturates at zero.
module ctrl_timeout #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] count;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
  // The decrement taken this cycle is the one that reaches zero.
  assign last = (count == W'(1));

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle instruction sequencer: accepts one instruction, decodes it and
// drives memory, ALU or nibble-register handshakes, then pulses retire or err.
//
// state  | meaning
// IDLE   | ready for a new instruction; latch it when instr_valid is high
// DECODE | one cycle; pick MEM / ALU / EXEC, alu_start high here for ALU ops
// MEM    | mem_req held until mem_ack or the timeout expires
// ALU    | wait for alu_done, no timeout
// EXEC   | one cycle; nibble strobes, undefined opcodes retire as no-ops
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int OPERAND_W   = 4,
  parameter int ALU_OP_W    = 3,
  parameter int ARITH_BIT   = OPCODE_ARITHMETIC_BIT,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [OPCODE_W+OPERAND_W-1:0] instr,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  output logic                   mem_req,
  output logic                   mem_we,
  input  logic                   mem_ack,
  output logic [OPERAND_W-1:0]   addr_offset,
  output logic [ALU_OP_W-1:0]    alu_op,
  output logic [OPERAND_W-1:0]   alu_shamt,
  output logic                   alu_start,
  input  logic                   alu_done,
  output logic                   nibble_read,
  output logic                   nibble_hl,
  output logic [OPERAND_W-1:0]   nibble_out,
  output logic [OPERAND_W-1:0]   reg_sel,
  output logic [OPERAND_W/2-1:0] reg16_src,
  output logic [OPERAND_W/2-1:0] reg16_dst,
  output logic                   busy,
  output logic                   retire,
  output logic                   err
);

  localparam int INSTR_W = OPCODE_W + OPERAND_W;
  localparam int TMO_W   = $clog2(MEM_TIMEOUT + 1);

  state_e               state;
  logic [INSTR_W-1:0]   instr_q;
  logic [OPCODE_W-1:0]  opcode_q;
  logic [OPCODE_W-1:0]  opcode_in;
  logic [OPERAND_W-1:0] operand_q;
  logic                 tmo_load;
  logic                 tmo_dec;
  logic                 tmo_zero;
  logic                 tmo_last;

  function automatic logic is_mem_op(input logic [OPCODE_W-1:0] op);
    return (op == OPCODE_W'(OPCODE_LDB)) || (op == OPCODE_W'(OPCODE_STB));
  endfunction

  assign opcode_q  = instr_q[INSTR_W-1 -: OPCODE_W];
  assign operand_q = instr_q[OPERAND_W-1:0];
  assign opcode_in = instr[INSTR_W-1 -: OPCODE_W];

  // Field outputs follow the latched copy so they hold for the whole operation.
  assign addr_offset = operand_q;
  assign nibble_out  = operand_q;
  assign reg_sel     = operand_q;
  assign alu_shamt   = operand_q;
  assign reg16_src   = operand_q[OPERAND_W-1 -: OPERAND_W/2];
  assign reg16_dst   = operand_q[OPERAND_W/2-1:0];
  assign alu_op      = opcode_q[ALU_OP_W-1:0];

  // Counter is armed in DECODE and only counts MEM cycles without an ack.
  assign tmo_load = (state == ST_DECODE);
  assign tmo_dec  = (state == ST_MEM) && !mem_ack;

  ctrl_timeout #(
    .W(TMO_W)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmo_load),
    .load_val(TMO_W'(MEM_TIMEOUT)),
    .dec     (tmo_dec),
    .zero    (tmo_zero),
    .last    (tmo_last)
  );

  // Sequencer FSM; every control output is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      instr_q     <= '0;
      instr_ready <= 1'b1;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      alu_start   <= 1'b0;
      nibble_read <= 1'b0;
      nibble_hl   <= 1'b0;
      busy        <= 1'b0;
      retire      <= 1'b0;
      err         <= 1'b0;
    end else begin
      retire      <= 1'b0;
      err         <= 1'b0;
      alu_start   <= 1'b0;
      nibble_read <= 1'b0;
      nibble_hl   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_q     <= instr;
            state       <= ST_DECODE;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            // Decoded from the word being latched so the pulse lands in DECODE.
            alu_start   <= !is_mem_op(opcode_in) && !opcode_in[ARITH_BIT];
          end
        end
        ST_DECODE: begin
          if (is_mem_op(opcode_q)) begin
            state   <= ST_MEM;
            mem_req <= 1'b1;
            mem_we  <= (opcode_q == OPCODE_W'(OPCODE_STB));
          end else if (!opcode_q[ARITH_BIT]) begin
            state <= ST_ALU;
          end else begin
            state       <= ST_EXEC;
            nibble_read <= (opcode_q == OPCODE_W'(OPCODE_LNL)) ||
                           (opcode_q == OPCODE_W'(OPCODE_LNH));
            nibble_hl   <= (opcode_q == OPCODE_W'(OPCODE_LNH));
          end
        end
        ST_MEM: begin
          // An ack arriving on the final counted cycle still wins over the timeout.
          if (mem_ack || tmo_last || tmo_zero) begin
            retire      <= mem_ack;
            err         <= !mem_ack;
            state       <= ST_IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            busy        <= 1'b0;
            instr_ready <= 1'b1;
          end
        end
        ST_ALU: begin
          if (alu_done) begin
            retire      <= 1'b1;
            state       <= ST_IDLE;
            busy        <= 1'b0;
            instr_ready <= 1'b1;
          end
        end
        ST_EXEC: begin
          retire      <= 1'b1;
          state       <= ST_IDLE;
          busy        <= 1'b0;
          instr_ready <= 1'b1;
        end
        default: begin
          state       <= ST_IDLE;
          mem_req     <= 1'b0;
          mem_we      <= 1'b0;
          busy        <= 1'b0;
          instr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: directed scenarios plus randomized
// instructions checked against a cycle-timeline model of the sequencer.
module tb_ctrl_seq;
  import ctrl_seq_pkg::*;

  localparam int T = 15;

  logic       clk;
  logic       rst_n;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       mem_req;
  logic       mem_we;
  logic       mem_ack;
  logic [3:0] addr_offset;
  logic [2:0] alu_op;
  logic [3:0] alu_shamt;
  logic       alu_start;
  logic       alu_done;
  logic       nibble_read;
  logic       nibble_hl;
  logic [3:0] nibble_out;
  logic [3:0] reg_sel;
  logic [1:0] reg16_src;
  logic [1:0] reg16_dst;
  logic       busy;
  logic       retire;
  logic       err;

  int checks = 0;
  int errors = 0;

  ctrl_seq #(
    .OPCODE_W(4), .OPERAND_W(4), .ALU_OP_W(3), .ARITH_BIT(3), .MEM_TIMEOUT(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .addr_offset(addr_offset), .alu_op(alu_op),
    .alu_shamt(alu_shamt), .alu_start(alu_start), .alu_done(alu_done),
    .nibble_read(nibble_read), .nibble_hl(nibble_hl), .nibble_out(nibble_out),
    .reg_sel(reg_sel), .reg16_src(reg16_src), .reg16_dst(reg16_dst),
    .busy(busy), .retire(retire), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  // Outputs are sampled and inputs driven on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if ({instr_ready, busy, mem_req, mem_we, alu_start, nibble_read, nibble_hl, retire, err} !== 9'b1_0000_0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 100000000",
               {instr_ready, busy, mem_req, mem_we, alu_start, nibble_read, nibble_hl, retire, err});
    end
    checks++;
    if ({addr_offset, alu_op, reg_sel, reg16_src, reg16_dst} !== 15'd0) begin
      errors++;
      $display("FAIL reset_fields: got %h required 0", {addr_offset, alu_op, reg_sel, reg16_src, reg16_dst});
    end
  endtask

  task automatic test_nibble();
    instr = {4'(OPCODE_LNH), 4'hA};
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    instr = 8'h00;
    checks++;
    if ({instr_ready, busy} !== 2'b01) begin
      errors++;
      $display("FAIL nibble_accept: ready/busy got %b required 01", {instr_ready, busy});
    end
    step();
    checks++;
    if ({nibble_read, nibble_hl, nibble_out, retire} !== {1'b1, 1'b1, 4'hA, 1'b0}) begin
      errors++;
      $display("FAIL nibble_exec: got %b required 1110100", {nibble_read, nibble_hl, nibble_out, retire});
    end
    step();
    checks++;
    if ({retire, busy, instr_ready, nibble_read} !== 4'b1010) begin
      errors++;
      $display("FAIL nibble_retire: got %b required 1010", {retire, busy, instr_ready, nibble_read});
    end
    step();
    checks++;
    if (retire !== 1'b0) begin
      errors++;
      $display("FAIL nibble_pulse: retire got %b required 0", retire);
    end
  endtask

  task automatic test_load_byte();
    instr = {4'(OPCODE_LDB), 4'h5};
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL ldb_decode: mem_req got %b required 0", mem_req);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({mem_req, mem_we, addr_offset, retire} !== {1'b1, 1'b0, 4'h5, 1'b0}) begin
        errors++;
        $display("FAIL ldb_mem[%0d]: got %b required 1001010", i, {mem_req, mem_we, addr_offset, retire});
      end
      mem_ack = (i == 4);
    end
    step();
    mem_ack = 1'b0;
    checks++;
    if ({retire, err, mem_req} !== 3'b100) begin
      errors++;
      $display("FAIL ldb_retire: retire/err/mem_req got %b required 100", {retire, err, mem_req});
    end
  endtask

  task automatic test_timeout();
    for (int rep = 0; rep < 2; rep++) begin
      instr = {4'(OPCODE_STB), 4'h3};
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      for (int i = 0; i < T; i++) begin
        step();
        checks++;
        if ({mem_req, mem_we, err, retire} !== 4'b1100) begin
          errors++;
          $display("FAIL stb_wait[%0d,%0d]: got %b required 1100", rep, i, {mem_req, mem_we, err, retire});
        end
        mem_ack = (rep == 1) && (i == T - 1);
      end
      step();
      mem_ack = 1'b0;
      checks++;
      if ({err, retire, instr_ready, mem_req} !== ((rep == 1) ? 4'b0110 : 4'b1010)) begin
        errors++;
        $display("FAIL stb_end[%0d]: err/retire/ready/req got %b required %b", rep,
                 {err, retire, instr_ready, mem_req}, (rep == 1) ? 4'b0110 : 4'b1010);
      end
    end
  endtask

  task automatic test_alu();
    int opc;
    opc = $urandom_range(0, 7);
    instr = {4'(opc), 4'h7};
    instr_valid = 1'b1;
    alu_done = 1'b1;
    step();
    instr_valid = 1'b0;
    checks++;
    if ({alu_start, alu_shamt, alu_op, busy} !== {1'b1, 4'h7, 3'(opc), 1'b1}) begin
      errors++;
      $display("FAIL alu_decode: got %b required %b", {alu_start, alu_shamt, alu_op, busy}, {1'b1, 4'h7, 3'(opc), 1'b1});
    end
    step();
    alu_done = 1'b0;
    checks++;
    if ({alu_start, retire, busy} !== 3'b001) begin
      errors++;
      $display("FAIL alu_first: start/retire/busy got %b required 001", {alu_start, retire, busy});
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({retire, busy} !== 2'b01) begin
        errors++;
        $display("FAIL alu_wait[%0d]: retire/busy got %b required 01", i, {retire, busy});
      end
      alu_done = (i == 1);
    end
    step();
    alu_done = 1'b0;
    checks++;
    if ({retire, busy, err} !== 3'b100) begin
      errors++;
      $display("FAIL alu_retire: retire/busy/err got %b required 100", {retire, busy, err});
    end
  endtask

  task automatic test_reset_mid();
    instr = {4'(OPCODE_LDB), 4'h9};
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, busy, instr_ready, retire, err} !== 5'b00100) begin
      errors++;
      $display("FAIL rst_async: req/busy/ready/retire/err got %b required 00100",
               {mem_req, busy, instr_ready, retire, err});
    end
    step();
    checks++;
    if ({mem_req, retire, err} !== 3'b000) begin
      errors++;
      $display("FAIL rst_hold: req/retire/err got %b required 000", {mem_req, retire, err});
    end
    rst_n = 1'b1;
    step();
    instr = 8'hC1;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    step();
    checks++;
    if ({retire, reg_sel} !== {1'b1, 4'h1}) begin
      errors++;
      $display("FAIL rst_after: retire/reg_sel got %b required 10001", {retire, reg_sel});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q [3];
    int ret_seen;
    ret_seen = 0;
    for (int j = 0; j < 3; j++) q[j] = {4'($urandom_range(10, 15)), 4'($urandom_range(0, 15))};
    instr_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      instr = q[j];
      checks++;
      if (instr_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b required 1", j, instr_ready);
      end
      step();
      instr = ~q[j];
      checks++;
      if ({instr_ready, reg_sel, reg16_src, reg16_dst, nibble_out} !==
          {1'b0, q[j][3:0], q[j][3:2], q[j][1:0], q[j][3:0]}) begin
        errors++;
        $display("FAIL b2b_fields[%0d]: got %h required %h", j,
                 {instr_ready, reg_sel, reg16_src, reg16_dst, nibble_out},
                 {1'b0, q[j][3:0], q[j][3:2], q[j][1:0], q[j][3:0]});
      end
      step();
      checks++;
      if ({nibble_read, nibble_hl} !== {(q[j][7:4] == 4'hA) || (q[j][7:4] == 4'hB), q[j][7:4] == 4'hB}) begin
        errors++;
        $display("FAIL b2b_nibble[%0d]: got %b for opcode %h", j, {nibble_read, nibble_hl}, q[j][7:4]);
      end
      step();
      if (retire === 1'b1) ret_seen++;
    end
    instr_valid = 1'b0;
    checks++;
    if (ret_seen != 3) begin
      errors++;
      $display("FAIL b2b_retires: got %0d required 3", ret_seen);
    end
  endtask

  // Randomized instructions against a timeline model: decode cycle, then a
  // middle phase of d cycles, then the retire/err cycle back in IDLE.
  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int op, opr, k, d, end_c;
      bit is_mem, is_alu, is_exec, e_err;
      logic [8:0] got, exp;
      op  = $urandom_range(0, 15);
      opr = $urandom_range(0, 15);
      is_mem  = (op == OPCODE_LDB) || (op == OPCODE_STB);
      is_alu  = !is_mem && (op < 8);
      is_exec = !is_mem && !is_alu;
      k = is_mem ? $urandom_range(0, T + 2) : (is_alu ? $urandom_range(0, 5) : 0);
      d = is_exec ? 1 : (is_mem ? ((k < T) ? k + 1 : T) : k + 1);
      e_err = is_mem && (k >= T);
      end_c = 2 + d;
      checks++;
      if (instr_ready !== 1'b1) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b required 1", n, instr_ready);
      end
      instr = {4'(op), 4'(opr)};
      instr_valid = 1'b1;
      for (int c = 1; c <= end_c; c++) begin
        step();
        if (c == 1) begin
          instr_valid = 1'b0;
          checks++;
          if ({reg16_src, reg16_dst, alu_op, addr_offset} !== {2'(opr / 4), 2'(opr % 4), 3'(op % 8), 4'(opr)}) begin
            errors++;
            $display("FAIL rand_fields[%0d]: got %h required %h", n,
                     {reg16_src, reg16_dst, alu_op, addr_offset}, {2'(opr / 4), 2'(opr % 4), 3'(op % 8), 4'(opr)});
          end
        end
        got = {busy, retire, err, mem_req, mem_we, alu_start, nibble_read, nibble_hl, instr_ready};
        exp = {c < end_c,
               (c == end_c) && !e_err,
               (c == end_c) && e_err,
               is_mem && (c >= 2) && (c < end_c),
               (op == OPCODE_STB) && (c >= 2) && (c < end_c),
               is_alu && (c == 1),
               is_exec && (c == 2) && ((op == OPCODE_LNL) || (op == OPCODE_LNH)),
               is_exec && (c == 2) && (op == OPCODE_LNH),
               c == end_c};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL rand_ctrl[%0d] op=%h k=%0d cyc=%0d: got %b required %b", n, op, k, c, got, exp);
        end
        mem_ack  = is_mem && (c == 2 + k) && (c < end_c);
        alu_done = is_alu && (c < end_c) && ((c == 2 + k) || ((c == 1) && ($urandom_range(0, 1) == 1)));
      end
      mem_ack  = 1'b0;
      alu_done = 1'b0;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    instr       = 8'h00;
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
    alu_done    = 1'b0;
    step();
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_nibble();
    test_load_byte();
    test_timeout();
    test_alu();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
